pipeline_hazard_ctrl: RTL and testbench

//  Sequences the control word from control_pipeline through ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the decoder/datapath and the hazard controller.
// The master side drives the decoder fields, hold and mem_zero.
// The slave side (the controller) drives the enables and the stage control words.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             hold;
  logic             id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic             id_MemRead, id_MemWrite, id_Branch, id_Jump;
  logic [1:0]       id_ALUOp;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             mem_zero;

  logic             pc_write, ifid_write, ifid_flush;
  logic [1:0]       pc_src;
  logic             ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite;
  logic             ex_Branch, ex_MemtoReg, ex_RegWrite;
  logic [1:0]       ex_ALUOp;
  logic [REG_W-1:0] ex_rt;
  logic             mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
  logic             wb_MemtoReg, wb_RegWrite;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output hold, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
           id_MemWrite, id_Branch, id_Jump, id_ALUOp, id_rs, id_rt, mem_zero,
    input  pc_write, ifid_write, ifid_flush, pc_src,
           ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_Branch, ex_MemtoReg,
           ex_RegWrite, ex_ALUOp, ex_rt,
           mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite,
           wb_MemtoReg, wb_RegWrite, stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
           id_MemWrite, id_Branch, id_Jump, id_ALUOp, id_rs, id_rt, mem_zero,
    output pc_write, ifid_write, ifid_flush, pc_src,
           ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_Branch, ex_MemtoReg,
           ex_RegWrite, ex_ALUOp, ex_rt,
           mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite,
           wb_MemtoReg, wb_RegWrite, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a classic 5-stage pipe: carries decoder control through
// ID/EX, EX/MEM and MEM/WB, stalls on load-use, flushes on jump (ID) and taken
// branch (MEM), and counts stall/flush events with saturating counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]       ALUOp;
    logic [REG_W-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic MemRead, MemWrite, MemtoReg, RegWrite, Branch;
  } exmem_t;

  typedef struct packed {
    logic MemtoReg, RegWrite;
  } memwb_t;

  idex_t            id_ctl, idex_d, idex_q;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;
  logic             br_taken, load_use;
  logic             stall_inc, flush_inc;
  logic             pc_write, ifid_write, ifid_flush;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Decoder word as it would enter ID/EX; RegDst/MemtoReg are don't-cares
  // for non-writing instructions, so mask them to keep x out of the pipe.
  always_comb begin
    id_ctl          = '0;
    id_ctl.RegDst   = bus.id_RegDst & bus.id_RegWrite;
    id_ctl.ALUSrc   = bus.id_ALUSrc;
    id_ctl.MemtoReg = bus.id_MemtoReg & bus.id_RegWrite;
    id_ctl.RegWrite = bus.id_RegWrite;
    id_ctl.MemRead  = bus.id_MemRead;
    id_ctl.MemWrite = bus.id_MemWrite;
    id_ctl.Branch   = bus.id_Branch;
    id_ctl.ALUOp    = bus.id_ALUOp;
    id_ctl.rt       = bus.id_rt;
  end

  assign br_taken = exmem_q.Branch & bus.mem_zero;
  // A jump in ID is flushed anyway, so its operands cannot cause a stall.
  assign load_use = idex_q.MemRead & ~bus.id_Jump & (idex_q.rt != '0) &
                    ((idex_q.rt == bus.id_rs) | (idex_q.rt == bus.id_rt));

  // Priority hold > taken branch > load-use > jump > normal; selects enables and next stage words.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = 2'b00;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    idex_d     = id_ctl;
    exmem_d    = {idex_q.MemRead, idex_q.MemWrite, idex_q.MemtoReg, idex_q.RegWrite, idex_q.Branch};
    memwb_d    = {exmem_q.MemtoReg, exmem_q.RegWrite};
    if (bus.hold) begin
      // Stage registers are gated off in the register process.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (br_taken) begin
      // Younger instructions in ID and EX are wrong-path; the branch retires harmlessly.
      pc_src     = 2'b01;
      ifid_flush = 1'b1;
      idex_d     = '0;
      exmem_d    = '0;
      flush_inc  = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_d     = '0;
      stall_inc  = 1'b1;
    end else if (bus.id_Jump) begin
      pc_src     = 2'b10;
      ifid_flush = 1'b1;
      idex_d     = '0;
      flush_inc  = 1'b1;
    end
  end

  // Pipeline registers and saturating event counters; everything freezes under hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!bus.hold) begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.pc_src       = pc_src;
  assign bus.ex_RegDst    = idex_q.RegDst;
  assign bus.ex_ALUSrc    = idex_q.ALUSrc;
  assign bus.ex_MemtoReg  = idex_q.MemtoReg;
  assign bus.ex_RegWrite  = idex_q.RegWrite;
  assign bus.ex_MemRead   = idex_q.MemRead;
  assign bus.ex_MemWrite  = idex_q.MemWrite;
  assign bus.ex_Branch    = idex_q.Branch;
  assign bus.ex_ALUOp     = idex_q.ALUOp;
  assign bus.ex_rt        = idex_q.rt;
  assign bus.mem_MemRead  = exmem_q.MemRead;
  assign bus.mem_MemWrite = exmem_q.MemWrite;
  assign bus.mem_MemtoReg = exmem_q.MemtoReg;
  assign bus.mem_RegWrite = exmem_q.RegWrite;
  assign bus.wb_MemtoReg  = memwb_q.MemtoReg;
  assign bus.wb_RegWrite  = memwb_q.RegWrite;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic, compared every cycle against an instruction-level model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  logic reset_n;
  bit   chk_en = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(16)) b16 ();
  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(4))  b4 ();

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));
  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(b4));

  assign b4.hold        = b16.hold;
  assign b4.id_RegDst   = b16.id_RegDst;
  assign b4.id_ALUSrc   = b16.id_ALUSrc;
  assign b4.id_MemtoReg = b16.id_MemtoReg;
  assign b4.id_RegWrite = b16.id_RegWrite;
  assign b4.id_MemRead  = b16.id_MemRead;
  assign b4.id_MemWrite = b16.id_MemWrite;
  assign b4.id_Branch   = b16.id_Branch;
  assign b4.id_Jump     = b16.id_Jump;
  assign b4.id_ALUOp    = b16.id_ALUOp;
  assign b4.id_rs       = b16.id_rs;
  assign b4.id_rt       = b16.id_rt;
  assign b4.mem_zero    = b16.mem_zero;

  // ---------------- model: one record per in-flight instruction ----------------
  typedef struct packed {
    logic regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]       aluop;
    logic [REG_W-1:0] rt;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  int     m_stall, m_flush;   // unbounded event counts; saturation applied on compare

  function automatic instr_t id_instr();
    instr_t r;
    r.regdst   = b16.id_RegWrite ? b16.id_RegDst : 1'b0;
    r.alusrc   = b16.id_ALUSrc;
    r.memtoreg = b16.id_RegWrite ? b16.id_MemtoReg : 1'b0;
    r.regwrite = b16.id_RegWrite;
    r.memread  = b16.id_MemRead;
    r.memwrite = b16.id_MemWrite;
    r.branch   = b16.id_Branch;
    r.aluop    = b16.id_ALUOp;
    r.rt       = b16.id_rt;
    return r;
  endfunction

  function automatic bit m_br();
    return m_mem.branch && b16.mem_zero;
  endfunction

  function automatic bit m_lu();
    return m_ex.memread && !b16.id_Jump && (m_ex.rt != 0) &&
           ((m_ex.rt == b16.id_rs) || (m_ex.rt == b16.id_rt));
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Model state update, one instruction-slot step per unheld clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_stall <= 0; m_flush <= 0;
    end else if (!b16.hold) begin
      m_wb <= m_mem;
      if (m_br()) begin
        m_mem <= '0; m_ex <= '0; m_flush <= m_flush + 1;
      end else begin
        m_mem <= m_ex;
        if (m_lu()) begin
          m_ex <= '0; m_stall <= m_stall + 1;
        end else if (b16.id_Jump) begin
          m_ex <= '0; m_flush <= m_flush + 1;
        end else begin
          m_ex <= id_instr();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic pw, iw, fl;
      logic [1:0] src;
      pw = 1'b1; iw = 1'b1; fl = 1'b0; src = 2'b00;
      if (b16.hold) begin pw = 1'b0; iw = 1'b0; end
      else if (m_br()) begin src = 2'b01; fl = 1'b1; end
      else if (m_lu()) begin pw = 1'b0; iw = 1'b0; end
      else if (b16.id_Jump) begin src = 2'b10; fl = 1'b1; end
      chk("pc_write",     b16.pc_write,     pw);
      chk("ifid_write",   b16.ifid_write,   iw);
      chk("ifid_flush",   b16.ifid_flush,   fl);
      chk("pc_src",       b16.pc_src,       src);
      chk("ex_RegDst",    b16.ex_RegDst,    m_ex.regdst);
      chk("ex_ALUSrc",    b16.ex_ALUSrc,    m_ex.alusrc);
      chk("ex_MemtoReg",  b16.ex_MemtoReg,  m_ex.memtoreg);
      chk("ex_RegWrite",  b16.ex_RegWrite,  m_ex.regwrite);
      chk("ex_MemRead",   b16.ex_MemRead,   m_ex.memread);
      chk("ex_MemWrite",  b16.ex_MemWrite,  m_ex.memwrite);
      chk("ex_Branch",    b16.ex_Branch,    m_ex.branch);
      chk("ex_ALUOp",     b16.ex_ALUOp,     m_ex.aluop);
      chk("ex_rt",        b16.ex_rt,        m_ex.rt);
      chk("mem_MemRead",  b16.mem_MemRead,  m_mem.memread);
      chk("mem_MemWrite", b16.mem_MemWrite, m_mem.memwrite);
      chk("mem_MemtoReg", b16.mem_MemtoReg, m_mem.memtoreg);
      chk("mem_RegWrite", b16.mem_RegWrite, m_mem.regwrite);
      chk("wb_MemtoReg",  b16.wb_MemtoReg,  m_wb.memtoreg);
      chk("wb_RegWrite",  b16.wb_RegWrite,  m_wb.regwrite);
      chk("stall_cnt",    b16.stall_cnt,    sat(m_stall, 16));
      chk("flush_cnt",    b16.flush_cnt,    sat(m_flush, 16));
      chk("stall_cnt4",   b4.stall_cnt,     sat(m_stall, 4));
      chk("flush_cnt4",   b4.flush_cnt,     sat(m_flush, 4));
      chk("pc_write4",    b4.pc_write,      pw);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_ins();
    b16.hold = 0; b16.id_RegDst = 0; b16.id_ALUSrc = 0; b16.id_MemtoReg = 0;
    b16.id_RegWrite = 0; b16.id_MemRead = 0; b16.id_MemWrite = 0; b16.id_Branch = 0;
    b16.id_Jump = 0; b16.id_ALUOp = 2'b00; b16.id_rs = '0; b16.id_rt = '0; b16.mem_zero = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic drv_lw(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
    clr_ins();
    b16.id_MemRead = 1; b16.id_RegWrite = 1; b16.id_MemtoReg = 1; b16.id_ALUSrc = 1;
    b16.id_rs = rs; b16.id_rt = rt;
  endtask

  task automatic drv_add(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
    clr_ins();
    b16.id_RegWrite = 1; b16.id_RegDst = 1; b16.id_ALUOp = 2'b10;
    b16.id_rs = rs; b16.id_rt = rt;
  endtask

  task automatic drv_beq();
    clr_ins();
    b16.id_Branch = 1; b16.id_ALUOp = 2'b01; b16.id_rs = 5'd2; b16.id_rt = 5'd3;
  endtask

  task automatic drv_rand();
    int k;
    b16.hold        = ($urandom_range(0, 9) == 0);
    b16.id_RegWrite = $urandom_range(0, 1);
    b16.id_RegDst   = $urandom_range(0, 1);
    b16.id_MemtoReg = $urandom_range(0, 1);
    b16.id_ALUSrc   = $urandom_range(0, 1);
    b16.id_MemRead  = ($urandom_range(0, 9) < 3);
    b16.id_MemWrite = ($urandom_range(0, 9) < 2);
    b16.id_Branch   = ($urandom_range(0, 9) < 2);
    b16.id_Jump     = ($urandom_range(0, 9) == 0);
    b16.id_ALUOp    = 2'($urandom_range(0, 3));
    k = $urandom_range(0, 3); b16.id_rs = REG_W'(k);
    k = $urandom_range(0, 3); b16.id_rt = REG_W'(k);
    b16.mem_zero    = $urandom_range(0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clr_ins();
    reset_n = 0;
    @(posedge clk); #1;
    chk_en = 1;
    step(); step();
    // reset state, literal
    at_neg();
    chk("rst pc_write",   b16.pc_write, 1);
    chk("rst ifid_write", b16.ifid_write, 1);
    chk("rst pc_src",     b16.pc_src, 0);
    chk("rst ex_RegWrite", b16.ex_RegWrite, 0);
    chk("rst stall_cnt",  b16.stall_cnt, 0);

    // load-use: lw $1 then add $2,$1,$3
    step(); reset_n = 1; drv_lw(5'd0, 5'd1);
    step(); drv_add(5'd1, 5'd3);
    at_neg();
    chk("lu pc_write",   b16.pc_write, 0);
    chk("lu ifid_write", b16.ifid_write, 0);
    step();
    at_neg();
    chk("lu ex_RegWrite bubble", b16.ex_RegWrite, 0);
    chk("lu stall_cnt",          b16.stall_cnt, 1);
    chk("lu pc_write resumes",   b16.pc_write, 1);
    step();
    at_neg();
    chk("lu add issued RegWrite", b16.ex_RegWrite, 1);
    chk("lu add issued ALUOp",    b16.ex_ALUOp, 2);
    chk("lu lw in wb",            b16.wb_MemtoReg, 1);

    // taken branch
    step(); drv_beq();
    step(); clr_ins();
    step(); drv_add(5'd4, 5'd5); b16.mem_zero = 1;
    at_neg();
    chk("br pc_src",     b16.pc_src, 1);
    chk("br ifid_flush", b16.ifid_flush, 1);
    step();
    at_neg();
    chk("br ex bubble",  b16.ex_RegWrite, 0);
    chk("br flush_cnt",  b16.flush_cnt, 1);
    chk("br mem bubble", b16.mem_RegWrite, 0);
    // not-taken branch
    step(); drv_beq();
    step(); clr_ins();
    step(); clr_ins();
    at_neg();
    chk("nt pc_src",     b16.pc_src, 0);
    chk("nt ifid_flush", b16.ifid_flush, 0);
    step();
    at_neg();
    chk("nt flush_cnt",  b16.flush_cnt, 1);

    // jump beats a would-be load-use
    step(); drv_lw(5'd0, 5'd5);
    step(); clr_ins(); b16.id_Jump = 1; b16.id_rt = 5'd5;
    at_neg();
    chk("j pc_src",     b16.pc_src, 2);
    chk("j ifid_flush", b16.ifid_flush, 1);
    chk("j pc_write",   b16.pc_write, 1);
    step(); clr_ins();
    at_neg();
    chk("j flush_cnt",  b16.flush_cnt, 2);
    chk("j stall_cnt",  b16.stall_cnt, 1);
    chk("j ifid_flush once", b16.ifid_flush, 0);

    // taken branch collides with load-use
    step(); drv_beq();
    step(); drv_lw(5'd0, 5'd6);
    step(); drv_add(5'd6, 5'd7); b16.mem_zero = 1;
    at_neg();
    chk("col pc_src",   b16.pc_src, 1);
    chk("col pc_write", b16.pc_write, 1);
    step(); clr_ins();
    at_neg();
    chk("col stall_cnt", b16.stall_cnt, 1);
    chk("col flush_cnt", b16.flush_cnt, 3);

    // hold for 4 cycles with a lw sitting in EX
    step(); drv_lw(5'd0, 5'd8);
    step(); drv_add(5'd8, 5'd1); b16.hold = 1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("hold pc_write",   b16.pc_write, 0);
      chk("hold ex_MemRead", b16.ex_MemRead, 1);
      chk("hold ex_rt",      b16.ex_rt, 8);
      chk("hold stall_cnt",  b16.stall_cnt, 1);
      step();
    end
    b16.hold = 0;
    at_neg();
    chk("post-hold stall", b16.pc_write, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step();
      drv_rand();
      reset_n = ($urandom_range(0, 299) != 0);
    end
    step(); reset_n = 1; clr_ins();

    // saturation: repeated lw $1 using $1 -> a stall every other cycle
    reset_n = 0;
    step(); reset_n = 1; drv_lw(5'd1, 5'd1);
    for (int i = 0; i < 51; i++) step();
    at_neg();
    chk("sat stall_cnt16", b16.stall_cnt, 25);
    chk("sat stall_cnt4",  b4.stall_cnt, 15);
    chk("sat stalling",    b16.pc_write, 0);
    // reset mid-stall, no clock edge needed
    reset_n = 0; #1;
    chk("rst mid stall_cnt",  b16.stall_cnt, 0);
    chk("rst mid stall_cnt4", b4.stall_cnt, 0);
    chk("rst mid ex_MemRead", b16.ex_MemRead, 0);
    chk("rst mid pc_write",   b16.pc_write, 1);
    step(); step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
